led_phase_scheduler: RTL
========================

# led_phase_scheduler

Time-multiplexing sequencer for the pulse-oximeter front end. Once the RED/IR settings search has finished, this block alternates the RED and IR LEDs at a fixed phase rate. On each phase entry it loads that channel's stored PGA gain and DC-compensation code into the analog chain. After a settling window it averages the ADC samples and publishes one value per channel per phase with a valid strobe. It sits between the settings-search controller (which supplies the per-channel settings) and the SpO2 datapath (which consumes the channel values).

## Interface
- PHASE_LEN, 10: cycles per LED phase; legal range 4..255.
- SETTLE_CYC, 3: cycles after phase entry before sampling starts.
- AVG_LOG2, 2: samples averaged per phase, N = 2^AVG_LOG2.
- Legality constraint: SETTLE_CYC + N <= PHASE_LEN-1.
- CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins sequencing; ignored while busy.
- stop  in  1  single-cycle pulse requesting a halt; ignored while idle.
- RED_PGA  in  4  stored RED PGA gain.
- RED_DC  in  7  stored RED DC-comp code.
- IR_PGA  in  4  stored IR PGA gain.
- IR_DC  in  7  stored IR DC-comp code.
- ADC  in  8  ADC sample, valid every cycle.
- LED_RED  out  1  RED LED drive.
- LED_IR  out  1  IR LED drive.
- PGA_Gain  out  4  gain applied to the PGA.
- DC_Comp  out  7  code applied to the DC-comp DAC.
- RED_ADC_Value  out  8  latest RED phase average.
- IR_ADC_Value  out  8  latest IR phase average.
- sample_valid  out  1  one-cycle strobe marking a value update.
- sample_ch  out  2  channel of the current strobe: 0 = RED, 1 = IR, 2 = DARK.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- States: IDLE, DARK (present only with the macro), RED, IR.
- Phase counter cnt runs 0..PHASE_LEN-1. It resets to 0 on every phase entry and advances one per cycle.
- Transitions:
  - IDLE goes to the first phase when start is seen.
  - At cnt == PHASE_LEN-1 the FSM moves to the next phase in sequence: RED→IR→RED, or DARK→RED→IR→DARK with the macro.
- Phase entry, i.e. the edge that sets cnt = 0:
  - The FSM registers PGA_Gain and DC_Comp from that channel's inputs. DARK uses the RED settings.
  - It sets the LED outputs: RED has LED_RED=1, LED_IR=0; IR has LED_RED=0, LED_IR=1; DARK has both 0.
  - Settings and LEDs are held constant for the whole phase. Input changes made mid-phase take effect at the next entry.
- Accumulation: while SETTLE_CYC <= cnt <= SETTLE_CYC+N-1, acc += ADC.
  - acc is (8+AVG_LOG2) bits wide and is cleared at phase entry.
  - avg = (acc + ADC) >> AVG_LOG2, truncating.
- Result edge: the clock edge at cnt == SETTLE_CYC+N-1.
  - The FSM writes avg to the channel register, pulses sample_valid for exactly one cycle, and drives sample_ch.
  - Those outputs are visible at cnt == SETTLE_CYC+N.
- stop is latched into a pending flag. At the next cnt == PHASE_LEN-1 with the flag set, the FSM enters IDLE and clears the flag.
  - On entering IDLE: LEDs go to 0, PGA_Gain and DC_Comp go to 0, and the channel value registers retain their contents.
- Simultaneous events:
  - start together with stop in IDLE: start wins.
  - stop on the last cycle of a phase: IDLE is entered at that edge.
  - start while busy: no effect.
- Async reset, including mid-phase, forces these values immediately:
  - state IDLE, cnt 0, acc 0, pending stop 0;
  - LED_RED 0, LED_IR 0, PGA_Gain 0, DC_Comp 0;
  - RED_ADC_Value 0, IR_ADC_Value 0, dark register 0;
  - sample_valid 0, sample_ch 0, busy 0.

## Timing
- Latency from start to phase entry: 1 cycle. With start sampled high at edge k, the entry outputs are visible after edge k+1.
- Latency from phase entry to sample_valid: SETTLE_CYC+N cycles.
- Full RED+IR cycle: 2·PHASE_LEN cycles without the macro, 3·PHASE_LEN with it.
- A halt completes at most PHASE_LEN cycles after stop.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Configuration
- DARK_PHASE_EN defined:
  - The sequence is DARK→RED→IR.
  - At the end of the DARK phase the average is stored in an internal dark register and sample_valid fires with sample_ch=2.
  - RED and IR values become max(avg − dark, 0), with the subtraction saturating at 0.
- DARK_PHASE_EN undefined:
  - There is no DARK state and no dark register.
  - RED and IR values are the raw averages, and sample_ch never equals 2.

## Test plan
- Defaults, macro off, start, ADC=100 constant:
  - LED_RED=1 one cycle after start.
  - sample_valid appears 7 cycles after entry, with RED_ADC_Value=100 and ch=0.
  - IR entry occurs 10 cycles after RED entry.
- RED samples 100, 101, 102, 103 at cnt 3..6 → RED_ADC_Value=101. ADC values outside cnt 3..6 are set to 255 and must not affect the result.
- RED_PGA=5, RED_DC=40, IR_PGA=9, IR_DC=70:
  - PGA_Gain and DC_Comp alternate 5/40 and 9/70 at each phase entry.
  - Changing RED_PGA mid-RED-phase takes effect only at the next RED entry.
- stop pulsed at cnt=2 of IR:
  - Operation continues to cnt=9, then enters IDLE.
  - LEDs, PGA_Gain and DC_Comp go to 0, busy=0, and values are retained.
  - A start in that same cycle in IDLE restarts the sequence.
- Macro on:
  - dark=20, red=100 → dark strobe with ch=2, then RED=80.
  - dark=120, red=100 → RED=0 (saturated).
- rst_n asserted at cnt=5 of RED: every output is immediately at its reset value. After release, the block stays IDLE until start.

Source files
------------

// File: rtl/led_phase_scheduler.sv
// RED/IR LED time-multiplexing sequencer: loads per-channel PGA/DC settings at phase entry,
// averages ADC samples after settling and strobes one value per phase. Optional macro: DARK_PHASE_EN.
module led_phase_scheduler #(
    parameter int PHASE_LEN  = 10,
    parameter int SETTLE_CYC = 3,
    parameter int AVG_LOG2   = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] RED_PGA,
    input  logic [6:0] RED_DC,
    input  logic [3:0] IR_PGA,
    input  logic [6:0] IR_DC,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [3:0] PGA_Gain,
    output logic [6:0] DC_Comp,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic       sample_valid,
    output logic [1:0] sample_ch,
    output logic       busy
);

    localparam int AW = 8 + AVG_LOG2;
    localparam logic [7:0] CNT_LAST  = 8'(PHASE_LEN - 1);
    localparam logic [7:0] SMP_FIRST = 8'(SETTLE_CYC);
    localparam logic [7:0] SMP_LAST  = 8'(SETTLE_CYC + (1 << AVG_LOG2) - 1);

`ifdef DARK_PHASE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RED = 2'd1, S_IR = 2'd2, S_DARK = 2'd3} state_t;
    localparam state_t S_FIRST = S_DARK;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RED = 2'd1, S_IR = 2'd2} state_t;
    localparam state_t S_FIRST = S_RED;
`endif

    state_t          state_q, state_d, tgt_s;
    logic [7:0]      cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d, sum_s;
    logic [7:0]      avg_s, corr_s;
    logic            start_q, start_d, stop_pend_q, stop_pend_d, enter_s;
    logic            led_red_q, led_red_d, led_ir_q, led_ir_d;
    logic [3:0]      pga_q, pga_d;
    logic [6:0]      dc_q, dc_d;
    logic [7:0]      red_q, red_d, ir_q, ir_d;
    logic            valid_q, valid_d, busy_q, busy_d;
    logic [1:0]      ch_q, ch_d;
`ifdef DARK_PHASE_EN
    logic [7:0]      dark_q, dark_d;
`endif

    function automatic state_t next_phase(input state_t s);
        state_t n;
        case (s)
            S_RED:   n = S_IR;
`ifdef DARK_PHASE_EN
            S_IR:    n = S_DARK;
            S_DARK:  n = S_RED;
`else
            S_IR:    n = S_RED;
`endif
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // Next-state, accumulation and output-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        start_d     = 1'b0;
        stop_pend_d = stop_pend_q;
        led_red_d   = led_red_q;
        led_ir_d    = led_ir_q;
        pga_d       = pga_q;
        dc_d        = dc_q;
        red_d       = red_q;
        ir_d        = ir_q;
        valid_d     = 1'b0;
        ch_d        = ch_q;
        enter_s     = 1'b0;
        tgt_s       = state_q;
        sum_s       = acc_q + AW'(ADC);
        avg_s       = sum_s[AW-1:AVG_LOG2];
`ifdef DARK_PHASE_EN
        dark_d      = dark_q;
        corr_s      = (avg_s > dark_q) ? (avg_s - dark_q) : 8'd0;
`else
        corr_s      = avg_s;
`endif

        if (state_q == S_IDLE) begin
            // start is registered once so entry lands one cycle after it is sampled
            start_d = start;
            if (start_q) begin
                enter_s = 1'b1;
                tgt_s   = S_FIRST;
            end else begin
                enter_s = 1'b0;
            end
        end else if (cnt_q == CNT_LAST) begin
            if (stop_pend_q || stop) begin
                state_d     = S_IDLE;
                cnt_d       = 8'd0;
                acc_d       = '0;
                stop_pend_d = 1'b0;
                led_red_d   = 1'b0;
                led_ir_d    = 1'b0;
                pga_d       = 4'd0;
                dc_d        = 7'd0;
            end else begin
                enter_s = 1'b1;
                tgt_s   = next_phase(state_q);
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
            if (stop) begin
                stop_pend_d = 1'b1;
            end else begin
                stop_pend_d = stop_pend_q;
            end
            if (cnt_q >= SMP_FIRST && cnt_q <= SMP_LAST) begin
                acc_d = sum_s;
            end else begin
                acc_d = acc_q;
            end
            if (cnt_q == SMP_LAST) begin
                valid_d = 1'b1;
                case (state_q)
                    S_RED:  begin red_d = corr_s; ch_d = 2'd0; end
                    S_IR:   begin ir_d  = corr_s; ch_d = 2'd1; end
`ifdef DARK_PHASE_EN
                    S_DARK: begin dark_d = avg_s; ch_d = 2'd2; end
`endif
                    default: valid_d = 1'b0;
                endcase
            end else begin
                valid_d = 1'b0;
            end
        end

        if (enter_s) begin
            state_d = tgt_s;
            cnt_d   = 8'd0;
            acc_d   = '0;
            case (tgt_s)
                S_RED:   begin led_red_d = 1'b1; led_ir_d = 1'b0; pga_d = RED_PGA; dc_d = RED_DC; end
                S_IR:    begin led_red_d = 1'b0; led_ir_d = 1'b1; pga_d = IR_PGA;  dc_d = IR_DC;  end
`ifdef DARK_PHASE_EN
                S_DARK:  begin led_red_d = 1'b0; led_ir_d = 1'b0; pga_d = RED_PGA; dc_d = RED_DC; end
`endif
                default: begin led_red_d = 1'b0; led_ir_d = 1'b0; pga_d = 4'd0;    dc_d = 7'd0;   end
            endcase
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            acc_q       <= '0;
            start_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            led_red_q   <= 1'b0;
            led_ir_q    <= 1'b0;
            pga_q       <= 4'd0;
            dc_q        <= 7'd0;
            red_q       <= 8'd0;
            ir_q        <= 8'd0;
            valid_q     <= 1'b0;
            ch_q        <= 2'd0;
            busy_q      <= 1'b0;
`ifdef DARK_PHASE_EN
            dark_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            start_q     <= start_d;
            stop_pend_q <= stop_pend_d;
            led_red_q   <= led_red_d;
            led_ir_q    <= led_ir_d;
            pga_q       <= pga_d;
            dc_q        <= dc_d;
            red_q       <= red_d;
            ir_q        <= ir_d;
            valid_q     <= valid_d;
            ch_q        <= ch_d;
            busy_q      <= busy_d;
`ifdef DARK_PHASE_EN
            dark_q      <= dark_d;
`endif
        end
    end

    assign LED_RED       = led_red_q;
    assign LED_IR        = led_ir_q;
    assign PGA_Gain      = pga_q;
    assign DC_Comp       = dc_q;
    assign RED_ADC_Value = red_q;
    assign IR_ADC_Value  = ir_q;
    assign sample_valid  = valid_q;
    assign sample_ch     = ch_q;
    assign busy          = busy_q;

endmodule
